// File: rtl/mul_shift_add.sv
// Sequential shift-and-add multiplier with sign/magnitude handling and early termination.
// Operands arrive on a shared bus: multiplicand in LOADA, multiplier in LOADB.
module mul_shift_add #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 signed_mode,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOADA = 3'd1,
        ST_LOADB = 3'd2,
        ST_CALC  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1) without overflow.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        logic [WIDTH-1:0] m;
        if (is_signed && v[WIDTH-1]) begin
            m = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            m = v;
        end
        return m;
    endfunction

    state_t           state_r;
    logic [PW-1:0]    a_r;
    logic [WIDTH-1:0] b_r;
    logic [PW-1:0]    p_r;
    logic             mode_r;
    logic             sign_a_r;
    logic             neg_r;

    logic [PW-1:0]    acc_s;
    logic [WIDTH-1:0] b_shift_s;
    logic [PW-1:0]    result_s;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic             sign_b_s;

    // Datapath for one CALC step plus operand magnitude conversion.
    always_comb begin
        if (b_r[0]) begin
            acc_s = p_r + a_r;
        end else begin
            acc_s = p_r;
        end
        b_shift_s = {1'b0, b_r[WIDTH-1:1]};
        if (neg_r) begin
            result_s = ~acc_s + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            result_s = acc_s;
        end
        mag_a_s  = magnitude(data_in, signed_mode);
        mag_b_s  = magnitude(data_in, mode_r);
        sign_b_s = mode_r & data_in[WIDTH-1];
    end

    // Controller FSM with registered datapath state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            a_r      <= {PW{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            p_r      <= {PW{1'b0}};
            mode_r   <= 1'b0;
            sign_a_r <= 1'b0;
            neg_r    <= 1'b0;
            product  <= {PW{1'b0}};
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_LOADA;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOADA: begin
                    mode_r   <= signed_mode;
                    sign_a_r <= signed_mode & data_in[WIDTH-1];
                    a_r      <= {{WIDTH{1'b0}}, mag_a_s};
                    state_r  <= ST_LOADB;
                end
                ST_LOADB: begin
                    b_r   <= mag_b_s;
                    neg_r <= mode_r & (sign_a_r ^ sign_b_s);
                    p_r   <= {PW{1'b0}};
                    // A zero multiplier skips CALC entirely; -0 is still 0.
                    if (mag_b_s == {WIDTH{1'b0}}) begin
                        state_r <= ST_DONE;
                        product <= {PW{1'b0}};
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    p_r <= acc_s;
                    a_r <= {a_r[PW-2:0], 1'b0};
                    b_r <= b_shift_s;
                    if (b_shift_s == {WIDTH{1'b0}}) begin
                        state_r <= ST_DONE;
                        product <= result_s;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state_r <= ST_LOADA;
                        done    <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_shift_add.sv
// Self-checking bench: directed table, corner sequences, random WIDTH=16 ops, exhaustive WIDTH=4 sweep.
module tb_mul_shift_add;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] data_in;
    logic        signed_mode;
    logic [31:0] product;
    logic        done;
    logic        busy;

    logic        start4;
    logic [3:0]  data_in4;
    logic        signed_mode4;
    logic [7:0]  product4;
    logic        done4;
    logic        busy4;

    int checks = 0;
    int errors = 0;

    mul_shift_add #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .signed_mode(signed_mode), .product(product), .done(done), .busy(busy)
    );

    mul_shift_add #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .data_in(data_in4),
        .signed_mode(signed_mode4), .product(product4), .done(done4), .busy(busy4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        bit          m;
        logic [31:0] p;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: true product of the operands, truncated to 2w bits.
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input bit m);
        longint sa, sb;
        logic [63:0] mask;
        mask = (64'd1 << (2 * w)) - 64'd1;
        sa = longint'(a & ((32'd1 << w) - 32'd1));
        sb = longint'(b & ((32'd1 << w) - 32'd1));
        if (m && a[w-1]) sa = sa - (longint'(1) << w);
        if (m && b[w-1]) sb = sb - (longint'(1) << w);
        return 64'(sa * sb) & mask;
    endfunction

    // Reference latency: 3 edges plus one CALC edge per bit up to the multiplier's top 1.
    function automatic int ref_lat(input int w, input logic [31:0] b, input bit m);
        longint mag;
        mag = longint'(b & ((32'd1 << w) - 32'd1));
        if (m && b[w-1]) mag = (longint'(1) << w) - mag;
        if (mag == 0) return 3;
        return 3 + $clog2(mag + 1);
    endfunction

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input bit m,
                         input bit pulse, output logic [31:0] prod, output int lat);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("loada_busy", 64'(busy), 64'd1);
        check("loada_done", 64'(done), 64'd0);
        data_in = a;
        signed_mode = m;
        @(negedge clk);
        data_in = b;
        signed_mode = ~m;
        @(negedge clk);
        data_in = 16'($urandom);
        signed_mode = 1'($urandom);
        lat = 3;
        while (!done && lat < 40) begin
            start = pulse && (lat == 3);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL timeout16: done=%0b after %0d edges, required 1", done, lat);
        end
        check("busy_with_done", 64'(busy), 64'd0);
        prod = product;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input bit m,
                        output logic [7:0] prod, output int lat);
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        data_in4 = a;
        signed_mode4 = m;
        @(negedge clk);
        data_in4 = b;
        @(negedge clk);
        lat = 3;
        while (!done4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done4) begin
            errors++;
            $display("FAIL timeout4: done=%0b after %0d edges, required 1", done4, lat);
        end
        prod = product4;
    endtask

    initial begin
        logic [31:0] p;
        logic [7:0]  p4;
        int          lat;
        logic [15:0] ra, rb;
        bit          rm;

        vecs[0] = '{16'd17,    16'd5,     1'b0, 32'd85,         6};
        vecs[1] = '{16'hFFFD,  16'd7,     1'b1, 32'hFFFFFFEB,   6};
        vecs[2] = '{16'h8000,  16'h8000,  1'b1, 32'h40000000,   19};
        vecs[3] = '{16'd1234,  16'd0,     1'b0, 32'd0,          3};
        vecs[4] = '{16'hFFFF,  16'hFFFF,  1'b0, 32'hFFFE0001,   19};
        vecs[5] = '{16'hFFFF,  16'hFFFF,  1'b1, 32'd1,          4};
        vecs[6] = '{16'h8000,  16'd1,     1'b1, 32'hFFFF8000,   4};
        vecs[7] = '{16'd7,     16'hFFFF,  1'b1, 32'hFFFFFFF9,   4};
        vecs[8] = '{16'd0,     16'd5,     1'b0, 32'd0,          6};
        vecs[9] = '{16'hFFFF,  16'd0,     1'b1, 32'd0,          3};

        rst = 1'b1;
        start = 1'b0;
        data_in = 16'd0;
        signed_mode = 1'b0;
        start4 = 1'b0;
        data_in4 = 4'd0;
        signed_mode4 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_product", 64'(product), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done4", 64'(done4), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_hold_done", 64'(done), 64'd0);
        check("idle_hold_busy", 64'(busy), 64'd0);

        // Directed table; consecutive entries also exercise back-to-back starts from DONE.
        for (int i = 0; i < 10; i++) begin
            run16(vecs[i].a, vecs[i].b, vecs[i].m, 1'b0, p, lat);
            check($sformatf("vec%0d_product", i), 64'(p), 64'(vecs[i].p));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
        end

        // DONE holds result until start.
        run16(16'd300, 16'd300, 1'b0, 1'b0, p, lat);
        repeat (3) @(negedge clk);
        check("hold_done", 64'(done), 64'd1);
        check("hold_product", 64'(product), 64'd90000);

        // start pulsed during CALC is ignored.
        run16(16'd1000, 16'h00FF, 1'b0, 1'b1, p, lat);
        check("calc_start_product", 64'(p), 64'd255000);
        check("calc_start_latency", 64'(lat), 64'd11);

        // Start held high in DONE: next edge leaves DONE.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_done_low", 64'(done), 64'd0);
        check("b2b_busy_high", 64'(busy), 64'd1);
        data_in = 16'd9;
        signed_mode = 1'b0;
        @(negedge clk);
        data_in = 16'd11;
        lat = 3;
        @(negedge clk);
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_product", 64'(product), 64'd99);
        check("b2b_latency", 64'(lat), 64'd7);

        // Reset in the middle of CALC aborts the operation.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data_in = 16'hFFFF;
        signed_mode = 1'b0;
        @(negedge clk);
        data_in = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        check("midcalc_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_done", 64'(done), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_product", 64'(product), 64'd0);
        repeat (20) @(negedge clk);
        check("abort_no_done", 64'(done), 64'd0);
        check("abort_idle_busy", 64'(busy), 64'd0);
        run16(16'hFFF0, 16'd100, 1'b1, 1'b0, p, lat);
        check("after_abort_product", 64'(p), 64'hFFFFF9C0);
        check("after_abort_latency", 64'(lat), 64'd10);

        // Random operations against the arithmetic model.
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom >> $urandom_range(0, 15));
            rm = 1'($urandom);
            run16(ra, rb, rm, 1'($urandom), p, lat);
            check("rand_product", 64'(p), ref_mul(16, 32'(ra), 32'(rb), rm));
            check("rand_latency", 64'(lat), 64'(ref_lat(16, 32'(rb), rm)));
        end

        // Exhaustive WIDTH=4 sweep in both modes.
        for (int mi = 0; mi < 2; mi++) begin
            for (int ai = 0; ai < 16; ai++) begin
                for (int bi = 0; bi < 16; bi++) begin
                    run4(4'(ai), 4'(bi), 1'(mi), p4, lat);
                    check("w4_product", 64'(p4), ref_mul(4, 32'(ai), 32'(bi), 1'(mi)));
                    check("w4_latency", 64'(lat), 64'(ref_lat(4, 32'(bi), 1'(mi))));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_shift_add.md
MUL_SHIFT_ADD -- requirements
Module: mul_shift_add

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a new multiplication; honoured only in IDLE or DONE.
REQ-005 The block SHALL have port data_in, input, WIDTH bits: shared operand bus, multiplicand then multiplier.
REQ-006 The block SHALL have port signed_mode, input, 1 bit: 1 means two's-complement operands; sampled in LOADA.
REQ-007 The block SHALL have port product, output, 2*WIDTH bits: result, valid while done=1.
REQ-008 The block SHALL have port done, output, 1 bit: high exactly while in DONE.
REQ-009 The block SHALL have port busy, output, 1 bit: high while in LOADA, LOADB or CALC.

Function
REQ-010 The controller SHALL be a five-state FSM: IDLE, LOADA, LOADB, CALC, DONE.
REQ-011 IDLE or DONE with start=1 SHALL go to LOADA; with start=0 SHALL hold state.
REQ-012 On the edge leaving LOADA, the block SHALL capture data_in and signed_mode, store |A| in a 2*WIDTH-bit zero-extended register, record sign_a, and go to LOADB.
REQ-013 On the edge leaving LOADB, the block SHALL capture data_in, store |B| in a WIDTH-bit register, set neg = signed_mode & (sign_a ^ sign_b), and clear P to 0.
REQ-014 LOADB SHALL go to DONE if |B|=0, else to CALC.
REQ-015 Magnitude of the most negative value (e.g. -32768, WIDTH=16) SHALL be 2^(WIDTH-1) as unsigned, with no overflow.
REQ-016 Each CALC edge SHALL add A to P if B[0]=1, shift A left 1, and shift B right 1 (logical).
REQ-017 CALC SHALL go to DONE on the edge where the shifted B becomes 0 (early termination); CALC cycles = index of the most significant 1 in |B| plus 1, at most WIDTH.
REQ-018 Latency SHALL be 3 + CALC-cycle count edges from the start-sampling edge to done=1; for |B|=0 it SHALL be 3 edges.
REQ-019 product SHALL equal -P (2*WIDTH-bit two's complement) when neg=1, else P; it SHALL be exact for all operand pairs in either mode.
REQ-020 start SHALL be ignored in LOADA, LOADB and CALC; data_in and signed_mode SHALL be don't-care outside LOADA/LOADB.
REQ-021 In DONE, product and done SHALL hold until start=1 is sampled; done SHALL fall on the edge entering LOADA.
REQ-022 Back-to-back operation SHALL be supported: start held high in DONE SHALL begin the next operation with no IDLE cycle.

Reset
REQ-023 rst=1 at a rising edge SHALL force state IDLE, with P, A, B, neg and sign_a cleared to 0.
REQ-024 After reset, product, done and busy SHALL be 0.
REQ-025 rst SHALL take priority over start and over any in-progress operation (reset mid-CALC aborts; no done pulse).
REQ-026 The block SHALL remain in IDLE after rst deasserts until start=1 is sampled.

Verification
REQ-027 WIDTH=16, unsigned: start, then data_in=17, then data_in=5 -> 3 CALC cycles, done after 6 edges, product=85, busy low with done.
REQ-028 WIDTH=16, signed: A=-3 (0xFFFD), B=7 -> product=0xFFFFFFEB (-21); A=-32768, B=-32768 -> product=0x40000000.
REQ-029 A=1234, B=0 -> LOADB goes directly to DONE, product=0, done after 3 edges; A=0xFFFF, B=0xFFFF unsigned -> 16 CALC cycles, product=0xFFFE0001.
REQ-030 Start pulsed during CALC -> ignored, result unchanged; start held high in DONE -> new operation starts, done low next edge.
REQ-031 rst asserted mid-CALC -> next edge state IDLE, product=0, done=0, busy=0; a new operation then completes correctly.
REQ-032 WIDTH=4: exhaustive sweep of all 256 operand pairs in both modes -> product matches the reference multiply.
